// File: rtl/pattern_gen_param.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen_param
//  Description : Builds a WIDTH-bit mask with N ones spread evenly over the
//                first M positions, one position per cycle (Bresenham).
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] m,
    input  logic [CNT_W-1:0] n,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_RUN   = 2'd1;
    localparam logic [1:0]       c_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] c_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_me;
    logic [CNT_W-1:0] r_ne;
    logic             r_lsb;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_k;
    logic [WIDTH-1:0] r_pattern;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_me;
    logic [WIDTH-1:0] w_fill;
    logic [CNT_W:0]   w_sum;
    logic             w_wrap;
    logic             w_hit;
    logic [CNT_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_pos;
    logic [WIDTH-1:0] w_bit;
    logic             w_last;

    assign w_me   = (m > c_WIDTH) ? c_WIDTH : m;
    // Shifting by the full width yields zero, so Me==WIDTH fills every bit.
    assign w_fill = lsb_first ? ~({WIDTH{1'b1}} << w_me) : ~({WIDTH{1'b1}} >> w_me);

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_ne};
    assign w_wrap    = (w_sum >= {1'b0, r_me});
    assign w_hit     = (r_acc == '0) || (w_sum > {1'b0, r_me});
    assign w_acc_nxt = w_wrap ? CNT_W'(w_sum - {1'b0, r_me}) : CNT_W'(w_sum);
    assign w_pos     = r_lsb ? r_k : (c_LAST - r_k);
    assign w_bit     = {{(WIDTH-1){1'b0}}, 1'b1} << w_pos;
    assign w_last    = (r_k == (r_me - c_ONE));

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state   <= c_IDLE;
            r_me      <= '0;
            r_ne      <= '0;
            r_lsb     <= 1'b0;
            r_acc     <= '0;
            r_k       <= '0;
            r_pattern <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_me  <= w_me;
                        r_ne  <= n;
                        r_lsb <= lsb_first;
                        r_acc <= '0;
                        r_k   <= '0;
                        if ((w_me == '0) || (n == '0)) begin
                            r_pattern <= '0;
                            r_cnt     <= '0;
                            r_state   <= c_DONE;
                            r_done    <= 1'b1;
                            r_valid   <= 1'b1;
                        end else if (n >= w_me) begin
                            r_pattern <= w_fill;
                            r_cnt     <= w_me;
                            r_state   <= c_DONE;
                            r_done    <= 1'b1;
                            r_valid   <= 1'b1;
                        end else begin
                            r_pattern <= '0;
                            r_cnt     <= '0;
                            r_state   <= c_RUN;
                            r_busy    <= 1'b1;
                            r_valid   <= 1'b0;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    if (w_hit) begin
                        r_pattern <= r_pattern | w_bit;
                    end
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, w_hit};
                    r_k   <= r_k + c_ONE;
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pattern  = r_pattern;
    assign busy     = r_busy;
    assign done     = r_done;
    assign valid    = r_valid;
    assign ones_cnt = r_cnt;

endmodule
`default_nettype wire
